// File: rtl/f4_pkg.sv
// Shared types for the fetch/data memory arbiter.
// FSM state enum, port-ID constants, small helper.
package f4_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_F = 1'b0;
  localparam port_id_t PORT_D = 1'b1;

  function automatic port_id_t f_other(
    input port_id_t p
  );
    return ~p;
  endfunction

endpackage

// File: rtl/f4_mem_arb_if.sv
// Bus bundle of the arbiter: fetch port, data port, memory side.
// slave = arbiter view; master = requesters + memory view.
interface f4_mem_arb_if #(
  parameter int DW = 16,
  parameter int AW = 16
);

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we,
    output mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/f4_arb_pick.sv
// Two-requester picker: lone requester wins, contention -> i_ptr.
// Ports: i_f_req, i_d_req, i_ptr in; o_win, o_any out.
module f4_arb_pick
  import f4_pkg::*;
(
  input  logic     i_f_req,
  input  logic     i_d_req,
  input  port_id_t i_ptr,
  output port_id_t o_win,
  output logic     o_any
);

  always_comb begin
    o_win = i_ptr;
    unique case (1'b1)
      (i_f_req && !i_d_req): o_win = PORT_F;
      (i_d_req && !i_f_req): o_win = PORT_D;
      default:               o_win = i_ptr;
    endcase
  end

  assign o_any = i_f_req | i_d_req;

endmodule

// File: rtl/f4_mem_arb.sv
// Fetch/data arbiter onto one single-port memory (IDLE/ACCESS/RESP).
// Ports: clk, rstn (async low), bus (f4_mem_arb_if.slave).
// Macro F4_ARB_RR_EN: round-robin on contention, else data wins.
module f4_mem_arb
  import f4_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic clk,
  input  logic rstn,
  f4_mem_arb_if.slave bus
);

  state_t        r_state;
  state_t        w_next;
  port_id_t      r_own;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_f_rdata;
  logic [DW-1:0] r_d_rdata;

  port_id_t      w_ptr;
  port_id_t      w_win;
  logic          w_any;
  logic          w_grant;
  logic          w_rd_done;

`ifdef F4_ARB_RR_EN
  port_id_t r_ptr;

  // Pointer names the port preferred on the next contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= PORT_F;
    end else if (w_grant) begin
      r_ptr <= f_other(w_win);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = PORT_D;
`endif

  f4_arb_pick u_pick (
    .i_f_req (bus.f_req),
    .i_d_req (bus.d_req),
    .i_ptr   (w_ptr),
    .o_win   (w_win),
    .o_any   (w_any)
  );

  // Gnt is combinational; keep it quiet while reset is held.
  assign w_grant = (r_state == S_IDLE)
                 && w_any && rstn;

  assign w_rd_done = (r_state == S_RESP)
                   && !r_we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_own     <= PORT_F;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_own <= w_win;
        if (w_win == PORT_D) begin
          r_addr  <= bus.d_addr;
          r_we    <= bus.d_we;
          r_wdata <= bus.d_wdata;
        end else begin
          r_addr  <= bus.f_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
      end
      if (w_rd_done) begin
        if (r_own == PORT_F) begin
          r_f_rdata <= bus.mem_rdata;
        end else begin
          r_d_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  // rdata bypasses mem_rdata in the completing RESP cycle so
  // it is valid alongside rvalid; the register holds it after.
  always_comb begin
    bus.f_gnt    = w_grant && (w_win == PORT_F);
    bus.d_gnt    = w_grant && (w_win == PORT_D);
    bus.mem_en   = (r_state == S_ACCESS);
    bus.mem_we   = (r_state == S_ACCESS) && r_we;
    bus.mem_addr = r_addr;
    bus.mem_wdata = r_wdata;
    bus.f_rvalid = (r_state == S_RESP)
                 && (r_own == PORT_F);
    bus.d_rvalid = (r_state == S_RESP)
                 && (r_own == PORT_D);
    bus.f_rdata  = r_f_rdata;
    bus.d_rdata  = r_d_rdata;
    if (w_rd_done && (r_own == PORT_F)) begin
      bus.f_rdata = bus.mem_rdata;
    end
    if (w_rd_done && (r_own == PORT_D)) begin
      bus.d_rdata = bus.mem_rdata;
    end
  end

endmodule

// File: doc/f4_mem_arb.md
F4_MEM_ARB -- requirements
Module: f4_mem_arb

Interface
REQ-001 Parameter: DW, 16, data word width in bits.
REQ-002 Parameter: AW, 16, address width in bits.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rstn  input  1  asynchronous, active-low reset.
REQ-005 Port: f_req  input  1  instruction-fetch read request; held with f_addr stable until f_gnt.
REQ-006 Port: f_addr  input  AW  fetch address.
REQ-007 Port: f_gnt / f_rvalid  output  1 each  fetch accepted / fetch data valid (one-cycle pulses).
REQ-008 Port: f_rdata  output  DW  fetch read data.
REQ-009 Port: d_req, d_we  input  1 each  data-port request, write enable (1 = write); held stable until d_gnt.
REQ-010 Port: d_addr / d_wdata  input  AW / DW  data-port address / write data.
REQ-011 Port: d_gnt / d_rvalid  output  1 each  data accepted / data access complete (one-cycle pulses).
REQ-012 Port: d_rdata  output  DW  data-port read data.
REQ-013 Port: mem_en, mem_we  output  1 each  single-port memory enable, write enable.
REQ-014 Port: mem_addr / mem_wdata  output  AW / DW  memory address / write data.
REQ-015 Port: mem_rdata  input  DW  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 In IDLE the winner's gnt is asserted combinationally in the same cycle; its address, we and wdata, and owner ID, are registered at that edge.
REQ-018 In ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata driven from registers; no other cycle drives mem_en=1.
REQ-019 In RESP: owner's rvalid=1 for one cycle; reads present mem_rdata on the owner's rdata; writes pulse rvalid as completion, rdata unchanged.
REQ-020 f_rdata and d_rdata are registered, hold their last value until next read completion of the same port.
REQ-021 Latency: gnt in cycle N, mem_en in N+1, rvalid in N+2; peak throughput one access per 3 cycles.
REQ-022 No gnt is issued in ACCESS or RESP; requests arriving then wait for the next IDLE.
REQ-023 Fetch port never asserts mem_we.
REQ-024 Simultaneous f_req and d_req in IDLE: winner per REQ-029/REQ-030; loser keeps req and is served in the next IDLE if still pending.

Reset
REQ-025 rstn low forces state IDLE immediately, independent of clk.
REQ-026 Reset values: all gnt, rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, f_rdata, d_rdata = 0.
REQ-027 Reset mid-ACCESS or mid-RESP abandons the transaction; no rvalid is issued for it.
REQ-028 Round-robin pointer (when compiled in) resets to "fetch preferred".

Configuration
REQ-029 Macro F4_ARB_RR_EN defined: round-robin; on contention the port not granted last wins, pointer updates on every grant.
REQ-030 Macro F4_ARB_RR_EN undefined: fixed priority, data port always wins contention; no pointer register exists.

Structure
REQ-031 Shared package f4_pkg holds the FSM state enum and the port-ID constants (PORT_F, PORT_D).
REQ-032 One sub-module f4_arb_pick: combinational two-requester picker taking both reqs and the pointer, returning the winner ID.

Verification
REQ-033 Fetch read only: f_req=1, f_addr=0x0010, mem[0x0010]=0xABCD -> f_gnt cycle N, mem_en N+1, f_rvalid N+2 with f_rdata=0xABCD.
REQ-034 Data write then read: d_we=1, d_addr=0x0200, d_wdata=0x1234, then d_we=0 same address -> mem_we=1 once, later d_rdata=0x1234.
REQ-035 Contention, F4_ARB_RR_EN undefined: both reqs held for 6 cycles -> d_gnt at cycles 0 and 3, f_gnt only after d_req drops.
REQ-036 Contention, F4_ARB_RR_EN defined: both reqs held -> grants alternate f, d, f, d every 3 cycles, fetch first after reset.
REQ-037 Reset during ACCESS: rstn low for 1 cycle -> all outputs 0 at once, no rvalid, next request served normally from IDLE.
REQ-038 Request during RESP: f_req raised in RESP -> f_gnt not before next IDLE cycle; f_rdata unchanged until its own f_rvalid.
